// File: rtl/commit_input_pkg.sv
// commit_input_pkg: shared types and constants for the commit input conditioning path
package commit_input_pkg;
    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } db_state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/commit_input_unit_debounce_fsm.sv
// debounce_fsm: per-button debouncer, accepts a level change only after DEBOUNCE_CYCLES stable cycles
// ports: clock, reset (async, active-high), din_sync (synchronised button),
//        press_pulse (one cycle on an accepted press), level (debounced button level)
module debounce_fsm
    import commit_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 230000
) (
    input  logic clock,
    input  logic reset,
    input  logic din_sync,
    output logic press_pulse,
    output logic level
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    db_state_t state;
    logic [CW-1:0] cnt;
    logic done;
    assign done = cnt == LAST;
    assign press_pulse = state == CHECK_PRESS && din_sync && done;
    assign level = state == PRESSED || state == CHECK_RELEASE;
    // the counter stops at LAST because the state always leaves on done
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
        end else
            case (state)
                IDLE:
                    if (din_sync) begin
                        state <= CHECK_PRESS;
                        cnt <= '0;
                    end
                CHECK_PRESS:
                    if (!din_sync) state <= IDLE;
                    else if (done) state <= PRESSED;
                    else cnt <= cnt + 1'b1;
                PRESSED:
                    if (!din_sync) begin
                        state <= CHECK_RELEASE;
                        cnt <= '0;
                    end
                default:
                    if (din_sync) state <= PRESSED;
                    else if (done) state <= IDLE;
                    else cnt <= cnt + 1'b1;
            endcase
endmodule

// File: rtl/commit_input_unit.sv
// commit_input_unit: synchronises and debounces the commit buttons and holds switch snapshots as tokens
// ports: clock, reset (async, active-high); comit1_raw/comit2_raw, switch_raw, negative_raw (raw board inputs);
//        ior1/ior2 (consume strobes); commit1/commit2 (slot valid), sw_data1/sw_data2, negative1/negative2
//        (captured snapshots); overrun (sticky, press landed on a still-valid slot)
module commit_input_unit
    import commit_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 230000,
    parameter int SW_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                comit1_raw,
    input  logic                comit2_raw,
    input  logic [SW_WIDTH-1:0] switch_raw,
    input  logic                negative_raw,
    input  logic                ior1,
    input  logic                ior2,
    output logic                commit1,
    output logic                commit2,
    output logic [SW_WIDTH-1:0] sw_data1,
    output logic [SW_WIDTH-1:0] sw_data2,
    output logic                negative1,
    output logic                negative2,
    output logic                overrun
);
    localparam int W = SW_WIDTH + 3;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [SW_WIDTH-1:0] sw_s;
    logic neg_s;
    logic [1:0] btn, press, level, take, ior, commit, neg;
    logic [SW_WIDTH-1:0] data [2];
    always_ff @(posedge clock or posedge reset)
        if (reset) sync_q <= '0;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], {negative_raw, switch_raw, comit2_raw, comit1_raw}};
    assign {neg_s, sw_s, btn} = sync_q[SYNC_STAGES-1];
    for (genvar g = 0; g < 2; g++) begin : g_db
        debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clock(clock),
            .reset(reset),
            .din_sync(btn[g]),
            .press_pulse(press[g]),
            .level(level[g])
        );
    end
    // a press is only accepted from the released side of the debouncer
    assign take = press & ~level;
    assign ior = {ior2, ior1};
    // overrun set wins over a clear in the same cycle
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            commit <= '0;
            neg <= '0;
            data <= '{default: '0};
            overrun <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (take[i]) begin
                    data[i] <= sw_s;
                    neg[i] <= neg_s;
                    commit[i] <= 1'b1;
                end else if (ior[i]) commit[i] <= 1'b0;
            overrun <= |(take & commit & ~ior) | (overrun & ~|(ior & commit));
        end
    assign {commit2, commit1} = commit;
    assign {negative2, negative1} = neg;
    assign sw_data1 = data[0];
    assign sw_data2 = data[1];
endmodule

// File: tb/tb_commit_input_unit.sv
// tb_commit_input_unit: scoreboard bench for commit_input_unit with DEBOUNCE_CYCLES=4
module tb_commit_input_unit;
    localparam int DB = 4;
    localparam int SW = 8;
    typedef struct packed {
        logic [SW-1:0] d;
        logic          n;
    } tok_t;
    logic clock = 1'b0, reset = 1'b1;
    logic comit1_raw = 1'b0, comit2_raw = 1'b0, negative_raw = 1'b0, ior1 = 1'b0, ior2 = 1'b0;
    logic [SW-1:0] switch_raw = '0;
    logic commit1, commit2, negative1, negative2, overrun;
    logic [SW-1:0] sw_data1, sw_data2;
    int errors = 0, checks = 0;
    tok_t q1[$], q2[$];
    logic p_c1 = 1'b0, p_c2 = 1'b0;
    tok_t p_t1 = '0, p_t2 = '0;
    always #5 clock = ~clock;
    commit_input_unit #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(SW)) dut (
        .clock(clock),
        .reset(reset),
        .comit1_raw(comit1_raw),
        .comit2_raw(comit2_raw),
        .switch_raw(switch_raw),
        .negative_raw(negative_raw),
        .ior1(ior1),
        .ior2(ior2),
        .commit1(commit1),
        .commit2(commit2),
        .sw_data1(sw_data1),
        .sw_data2(sw_data2),
        .negative1(negative1),
        .negative2(negative2),
        .overrun(overrun)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic pop(input int slot, input tok_t act);
        tok_t exp;
        if (slot == 1 ? q1.size() == 0 : q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot%0d unexpected token: got %0h expected none", slot, act);
        end else begin
            exp = slot == 1 ? q1.pop_front() : q2.pop_front();
            chk(slot == 1 ? "slot1 token" : "slot2 token", 32'(act), 32'(exp));
        end
    endtask
    // monitor: a token is presented when commit rises or the held snapshot changes while valid
    always @(negedge clock) begin
        if (!reset) begin
            if (commit1 && (!p_c1 || {sw_data1, negative1} != p_t1)) pop(1, {sw_data1, negative1});
            if (commit2 && (!p_c2 || {sw_data2, negative2} != p_t2)) pop(2, {sw_data2, negative2});
        end
        p_c1 = reset ? 1'b0 : commit1;
        p_c2 = reset ? 1'b0 : commit2;
        p_t1 = {sw_data1, negative1};
        p_t2 = {sw_data2, negative2};
    end
    task automatic press(input int slot, input logic [SW-1:0] sw, input logic n);
        switch_raw = sw;
        negative_raw = n;
        if (slot == 1) begin
            comit1_raw = 1'b1;
            q1.push_back({sw, n});
        end else begin
            comit2_raw = 1'b1;
            q2.push_back({sw, n});
        end
        tick(10);
        comit1_raw = 1'b0;
        comit2_raw = 1'b0;
        tick(10);
    endtask
    task automatic consume(input int slot);
        if (slot == 1) ior1 = 1'b1;
        else ior2 = 1'b1;
        tick(1);
        ior1 = 1'b0;
        ior2 = 1'b0;
    endtask
    initial begin
        tick(2);
        chk("reset commit1", 32'(commit1), 0);
        chk("reset commit2", 32'(commit2), 0);
        chk("reset data", 32'({sw_data1, sw_data2, negative1, negative2}), 0);
        chk("reset overrun", 32'(overrun), 0);
        reset = 1'b0;
        tick(2);
        // clean press latency
        switch_raw = 8'h5A;
        negative_raw = 1'b1;
        comit1_raw = 1'b1;
        q1.push_back({8'h5A, 1'b1});
        tick(6);
        chk("latency commit1 early", 32'(commit1), 0);
        tick(1);
        chk("latency commit1", 32'(commit1), 1);
        chk("latency sw_data1", 32'(sw_data1), 32'h5A);
        chk("latency negative1", 32'(negative1), 1);
        tick(3);
        comit1_raw = 1'b0;
        tick(10);
        chk("held commit1", 32'(commit1), 1);
        consume(1);
        chk("consume commit1", 32'(commit1), 0);
        chk("consume sw_data1", 32'(sw_data1), 32'h5A);
        consume(1);
        chk("idle ior1 sw_data1", 32'(sw_data1), 32'h5A);
        chk("idle ior1 overrun", 32'(overrun), 0);
        // bounce on press and on release
        switch_raw = 8'h3C;
        negative_raw = 1'b0;
        q2.push_back({8'h3C, 1'b0});
        for (int i = 0; i < 4; i++) begin
            comit2_raw = ~i[0];
            tick(1);
        end
        comit2_raw = 1'b1;
        tick(12);
        chk("bounce commit2", 32'(commit2), 1);
        chk("bounce sw_data2", 32'(sw_data2), 32'h3C);
        consume(2);
        chk("bounce consume commit2", 32'(commit2), 0);
        for (int i = 0; i < 4; i++) begin
            comit2_raw = i[0];
            tick(1);
        end
        comit2_raw = 1'b0;
        tick(12);
        chk("release bounce commit2", 32'(commit2), 0);
        // overrun
        press(1, 8'h11, 1'b0);
        chk("overrun first commit1", 32'(commit1), 1);
        chk("overrun first flag", 32'(overrun), 0);
        press(1, 8'h22, 1'b1);
        chk("overrun sw_data1", 32'(sw_data1), 32'h22);
        chk("overrun commit1", 32'(commit1), 1);
        chk("overrun flag", 32'(overrun), 1);
        consume(1);
        chk("overrun clear commit1", 32'(commit1), 0);
        chk("overrun clear flag", 32'(overrun), 0);
        // press pulse coincident with consume
        press(1, 8'h44, 1'b0);
        switch_raw = 8'h33;
        negative_raw = 1'b0;
        comit1_raw = 1'b1;
        q1.push_back({8'h33, 1'b0});
        tick(6);
        ior1 = 1'b1;
        tick(1);
        ior1 = 1'b0;
        chk("simul commit1", 32'(commit1), 1);
        chk("simul sw_data1", 32'(sw_data1), 32'h33);
        chk("simul overrun", 32'(overrun), 0);
        tick(3);
        comit1_raw = 1'b0;
        tick(10);
        consume(1);
        // async reset mid-debounce with a valid slot and overrun set
        press(2, 8'h55, 1'b1);
        press(2, 8'h66, 1'b0);
        chk("pre-reset overrun", 32'(overrun), 1);
        switch_raw = 8'h77;
        comit1_raw = 1'b1;
        tick(4);
        #2 reset = 1'b1;
        #1;
        chk("async reset commit2", 32'(commit2), 0);
        chk("async reset sw_data2", 32'(sw_data2), 0);
        chk("async reset overrun", 32'(overrun), 0);
        chk("async reset slot1", 32'({commit1, sw_data1, negative1}), 0);
        comit1_raw = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(12);
        chk("post-reset commit1", 32'(commit1), 0);
        chk("post-reset commit2", 32'(commit2), 0);
        // both slots pressed together
        switch_raw = 8'h12;
        negative_raw = 1'b1;
        comit1_raw = 1'b1;
        comit2_raw = 1'b1;
        q1.push_back({8'h12, 1'b1});
        q2.push_back({8'h12, 1'b1});
        tick(7);
        chk("dual commit1", 32'(commit1), 1);
        chk("dual commit2", 32'(commit2), 1);
        comit1_raw = 1'b0;
        comit2_raw = 1'b0;
        tick(10);
        consume(2);
        chk("dual ior2 commit2", 32'(commit2), 0);
        chk("dual ior2 commit1", 32'(commit1), 1);
        consume(1);
        chk("dual ior1 commit1", 32'(commit1), 0);
        tick(2);
        chk("slot1 tokens outstanding", 32'(q1.size()), 0);
        chk("slot2 tokens outstanding", 32'(q2.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
